// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared FSM, rw_type and port constants for the data-memory arbiter
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Access-size codes shared with risc_v and data_memory (funct3 style)
  localparam logic [2:0] RW_LB  = 3'b000;
  localparam logic [2:0] RW_LH  = 3'b001;
  localparam logic [2:0] RW_LW  = 3'b010;
  localparam logic [2:0] RW_LBU = 3'b100;
  localparam logic [2:0] RW_LHU = 3'b101;
  localparam logic [2:0] RW_SB  = 3'b000;
  localparam logic [2:0] RW_SH  = 3'b001;
  localparam logic [2:0] RW_SW  = 3'b010;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_EXT  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - one requester's command/response bundle toward the arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RW_W   = 3
) ();
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [RW_W-1:0]   rw_type;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              stall;

  modport master (output req, we, addr, rw_type, wdata,
                  input  gnt, done, rdata, stall);
  modport slave  (input  req, we, addr, rw_type, wdata,
                  output gnt, done, rdata, stall);
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// rtl/dmem_arbiter_rr_arb2.sv - two-way grant logic with a round-robin preference pointer
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  input  logic       fixed_prio,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  // After each completed transaction the other port becomes preferred
  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ~owner;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= PORT_CORE;
    else     ptr_q <= ptr_d;
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (fixed_prio || ptr_q == PORT_CORE) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares one data_memory port between the core and an external master
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RW_W       = 3,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [RW_W-1:0]   mem_rw_type,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RW_W-1:0]   rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic [1:0]        grant;
  logic              arb_advance;
  logic              done0, done1;

  rr_arb2 u_arb (
    .clk        (clk),
    .rst        (rst_n),
    .req        ({m1.req, m0.req}),
    .advance    (arb_advance),
    .owner      (owner_q),
    .fixed_prio (FIXED_PRIO != 0),
    .grant      (grant)
  );

  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= ST_IDLE;
      owner_q  <= PORT_CORE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      rw_q     <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          state_d = ST_ACCESS;
          owner_d = grant[1] ? PORT_EXT : PORT_CORE;
          if (grant[1]) begin
            we_d = m1.we; addr_d = m1.addr; rw_d = m1.rw_type; wdata_d = m1.wdata;
          end else begin
            we_d = m0.we; addr_d = m0.addr; rw_d = m0.rw_type; wdata_d = m0.wdata;
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        // Read data lands in the owner's register so it is valid in the done cycle
        if (!we_q) begin
          if (owner_q == PORT_EXT) rdata1_d = mem_rdata;
          else                     rdata0_d = mem_rdata;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done0       = (state_q == ST_RESP) && (owner_q == PORT_CORE);
    done1       = (state_q == ST_RESP) && (owner_q == PORT_EXT);
    arb_advance = (state_q == ST_RESP);
    mem_wr_en   = (state_q == ST_ACCESS) && we_q;
    mem_rd_en   = (state_q == ST_ACCESS) && !we_q;
    mem_addr    = addr_q;
    mem_rw_type = rw_q;
    mem_wdata   = wdata_q;
    m0.gnt      = (state_q == ST_IDLE) && grant[0];
    m1.gnt      = (state_q == ST_IDLE) && grant[1];
    m0.done     = done0;
    m1.done     = done1;
    m0.stall    = m0.req && !done0;
    m1.stall    = m1.req && !done1;
    m0.rdata    = rdata0_q;
    m1.rdata    = rdata1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - round-robin and fixed-priority arbiters driven side by side against a model
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load;
  logic        req [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [2:0]  rwt [2];
  logic [31:0] wdat [2];

  logic        gnt_o [2][2];
  logic        done_o [2][2];
  logic        stall_o [2][2];
  logic [31:0] rdata_o [2][2];
  logic        mwe [2];
  logic        mre [2];
  logic [31:0] maddr [2];
  logic [31:0] mwd [2];
  logic [31:0] mrd [2];
  logic [2:0]  mrw [2];

  int n_tests = 0;
  int n_fail  = 0;

  dmem_arbiter_if ifc [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_ifc
    assign ifc[g].req     = req[g % 2];
    assign ifc[g].we      = we[g % 2];
    assign ifc[g].addr    = addr[g % 2];
    assign ifc[g].rw_type = rwt[g % 2];
    assign ifc[g].wdata   = wdat[g % 2];
    assign gnt_o[g / 2][g % 2]   = ifc[g].gnt;
    assign done_o[g / 2][g % 2]  = ifc[g].done;
    assign stall_o[g / 2][g % 2] = ifc[g].stall;
    assign rdata_o[g / 2][g % 2] = ifc[g].rdata;
  end

  dmem_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst_n(rst), .m0(ifc[0]), .m1(ifc[1]),
    .mem_wr_en(mwe[0]), .mem_rd_en(mre[0]), .mem_addr(maddr[0]),
    .mem_rw_type(mrw[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0])
  );

  dmem_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst_n(rst), .m0(ifc[2]), .m1(ifc[3]),
    .mem_wr_en(mwe[1]), .mem_rd_en(mre[1]), .mem_addr(maddr[1]),
    .mem_rw_type(mrw[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1])
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i * 4);
  endfunction

  // data_memory stand-ins, one per arbiter
  logic [31:0] ram [2][64];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (load) for (int i = 0; i < 64; i++) ram[d][i] <= init_word(i);
      else if (mwe[d]) ram[d][maddr[d][7:2]] <= mwd[d];
    end
  end
  assign mrd[0] = ram[0][maddr[0][7:2]];
  assign mrd[1] = ram[1][maddr[1][7:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction-level model: stage 0 free, 1 strobe cycle, 2 done cycle
  int          stg [2];
  int          own [2];
  int          pref [2];
  logic        lwe [2];
  logic [31:0] laddr [2];
  logic [31:0] lwd [2];
  logic [31:0] lrdv [2];
  logic [2:0]  lrw [2];
  logic [31:0] erdq [2][2];
  logic [31:0] exp_mem [2][64];
  bit          armed = 1'b0;
  int          gq0 [$];
  int          gq1 [$];

  always @(negedge clk) begin : cmp
    logic [1:0] eg, ed;
    logic       ewr, erd;
    int         w;
    for (int d = 0; d < 2; d++) begin
      eg = 2'b00; ed = 2'b00; ewr = 1'b0; erd = 1'b0; w = 0;
      if (stg[d] == 0 && (req[0] || req[1])) begin
        if (req[0] && req[1]) w = (d == 1) ? 0 : pref[d];
        else                  w = req[0] ? 0 : 1;
        eg[w] = 1'b1;
      end else if (stg[d] == 1) begin
        ewr = lwe[d];
        erd = !lwe[d];
      end else if (stg[d] == 2) begin
        ed[own[d]] = 1'b1;
        if (!lwe[d]) erdq[d][own[d]] = lrdv[d];
      end
      if (armed) begin
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("d%0d_gnt%0d", d, p), 32'(gnt_o[d][p]), 32'(eg[p]));
          chk($sformatf("d%0d_done%0d", d, p), 32'(done_o[d][p]), 32'(ed[p]));
          chk($sformatf("d%0d_stall%0d", d, p), 32'(stall_o[d][p]), 32'(req[p] && !ed[p]));
          chk($sformatf("d%0d_rdata%0d", d, p), rdata_o[d][p], erdq[d][p]);
        end
        chk($sformatf("d%0d_wr_en", d), 32'(mwe[d]), 32'(ewr));
        chk($sformatf("d%0d_rd_en", d), 32'(mre[d]), 32'(erd));
        if (stg[d] == 1) begin
          chk($sformatf("d%0d_addr", d), maddr[d], laddr[d]);
          chk($sformatf("d%0d_wdata", d), mwd[d], lwd[d]);
          chk($sformatf("d%0d_rw", d), 32'(mrw[d]), 32'(lrw[d]));
        end
        if (d == 0) begin
          if (gnt_o[0][0]) gq0.push_back(0);
          if (gnt_o[0][1]) gq0.push_back(1);
        end else begin
          if (gnt_o[1][0]) gq1.push_back(0);
          if (gnt_o[1][1]) gq1.push_back(1);
        end
      end
      // A strobed write reaches memory even when reset lands on the same edge
      if (stg[d] == 1) begin
        lrdv[d] = exp_mem[d][laddr[d][7:2]];
        if (lwe[d]) exp_mem[d][laddr[d][7:2]] = lwd[d];
      end
      if (load) for (int i = 0; i < 64; i++) exp_mem[d][i] = init_word(i);
      if (rst) begin
        stg[d] = 0; pref[d] = 0; erdq[d][0] = '0; erdq[d][1] = '0;
      end else if (stg[d] == 0 && eg != 2'b00) begin
        own[d] = w; lwe[d] = we[w]; laddr[d] = addr[w]; lwd[d] = wdat[w]; lrw[d] = rwt[w];
        stg[d] = 1;
      end else if (stg[d] == 1) begin
        stg[d] = 2;
      end else if (stg[d] == 2) begin
        pref[d] = 1 - own[d];
        stg[d] = 0;
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic xact(input int p, input logic w, input logic [31:0] a, input logic [31:0] wd);
    bit ok = 1'b0;
    req[p] = 1'b1; we[p] = w; addr[p] = a; rwt[p] = w ? RW_SW : RW_LW; wdat[p] = wd;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = done_o[0][p];
    end
    chk($sformatf("xact_done_p%0d", p), 32'(ok), 32'd1);
    cyc();
    req[p] = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_rr [4];
    int exp_fp [4];
    exp_rr = '{0, 1, 0, 1};
    exp_fp = '{0, 0, 0, 0};
    load = 1'b1; rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; rwt[p] = '0; wdat[p] = '0;
    end
    cyc(); cyc();
    load = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_gnt0", 32'(gnt_o[d][0]), 32'd0);
      chk("rst_stall0", 32'(stall_o[d][0]), 32'd0);
      chk("rst_rd_en", 32'(mre[d]), 32'd0);
      chk("rst_mem_addr", maddr[d], 32'd0);
      chk("rst_mem_wdata", mwd[d], 32'd0);
      chk("rst_rdata1", rdata_o[d][1], 32'd0);
    end
    cyc(); rst = 1'b0;
    cyc();

    // Core LW from 0x10
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; rwt[0] = RW_LW;
    @(negedge clk);
    chk("rd_T_gnt", 32'(gnt_o[0][0]), 32'd1);
    chk("rd_T_stall", 32'(stall_o[0][0]), 32'd1);
    cyc(); @(negedge clk);
    chk("rd_T1_rd_en", 32'(mre[0]), 32'd1);
    chk("rd_T1_addr", maddr[0], 32'h10);
    chk("rd_T1_stall", 32'(stall_o[0][0]), 32'd1);
    cyc(); @(negedge clk);
    chk("rd_T2_done", 32'(done_o[0][0]), 32'd1);
    chk("rd_T2_rdata", rdata_o[0][0], 32'hDEADBEEF);
    chk("rd_T2_stall", 32'(stall_o[0][0]), 32'd0);
    cyc(); req[0] = 1'b0;

    // External SW to 0x20
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 32'h20; rwt[1] = RW_SW; wdat[1] = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt", 32'(gnt_o[0][1]), 32'd1);
    cyc(); @(negedge clk);
    chk("wr_wr_en", 32'(mwe[0]), 32'd1);
    chk("wr_rd_en", 32'(mre[0]), 32'd0);
    chk("wr_addr", maddr[0], 32'h20);
    chk("wr_wdata", mwd[0], 32'h12345678);
    chk("wr_rw", 32'(mrw[0]), 32'(3'b010));
    cyc(); @(negedge clk);
    chk("wr_done", 32'(done_o[0][1]), 32'd1);
    chk("wr_wr_en_off", 32'(mwe[0]), 32'd0);
    cyc(); req[1] = 1'b0;

    xact(0, 1'b0, 32'h20, 32'h0);
    chk("readback_rr", rdata_o[0][0], 32'h12345678);
    chk("readback_fp", rdata_o[1][0], 32'h12345678);
    xact(1, 1'b0, 32'h10, 32'h0);
    chk("m1_read", rdata_o[0][1], 32'hDEADBEEF);

    // Core drops req right after its grant
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h24; rwt[0] = RW_LW;
    @(negedge clk);
    chk("drop_gnt", 32'(gnt_o[0][0]), 32'd1);
    cyc(); req[0] = 1'b0;
    @(negedge clk);
    chk("drop_rd_en", 32'(mre[0]), 32'd1);
    cyc(); @(negedge clk);
    chk("drop_done", 32'(done_o[0][0]), 32'd1);
    chk("drop_rdata", rdata_o[0][0], 32'h1000_0024);
    cyc();

    // Core raises and drops req while the external access is in flight
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h28; rwt[1] = RW_LW;
    cyc(); req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h2C;
    cyc(); req[0] = 1'b0; req[1] = 1'b0;
    @(negedge clk);
    chk("early_m1_done", 32'(done_o[0][1]), 32'd1);
    cyc(); @(negedge clk);
    chk("early_no_gnt", 32'(gnt_o[0][0]), 32'd0);
    cyc(); @(negedge clk);
    chk("early_no_rd", 32'(mre[0]), 32'd0);
    chk("early_no_wr", 32'(mwe[0]), 32'd0);
    cyc();

    // Reset lands in the strobe cycle of an external read
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h30; rwt[1] = RW_LW;
    cyc(); rst = 1'b1;
    @(negedge clk);
    chk("abort_rd_en_before", 32'(mre[0]), 32'd1);
    cyc(); rst = 1'b0; req[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("abort_rd_en", 32'(mre[d]), 32'd0);
      chk("abort_no_done", 32'(done_o[d][1]), 32'd0);
      chk("abort_rdata1", rdata_o[d][1], 32'd0);
    end
    cyc();

    // Both ports request continuously
    gq0.delete(); gq1.delete();
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; rwt[0] = RW_LW;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h14; rwt[1] = RW_LW;
    repeat (12) cyc();
    req[0] = 1'b0;
    chk("rr_count", 32'(gq0.size()), 32'd4);
    chk("fp_count", 32'(gq1.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_order%0d", i), 32'((i < gq0.size()) ? gq0[i] : -1), 32'(exp_rr[i]));
      chk($sformatf("fp_order%0d", i), 32'((i < gq1.size()) ? gq1[i] : -1), 32'(exp_fp[i]));
    end
    gq0.delete(); gq1.delete();
    repeat (3) cyc();
    req[1] = 1'b0;
    chk("fp_after_drop_count", 32'(gq1.size()), 32'd1);
    chk("fp_after_drop_port", 32'((gq1.size() > 0) ? gq1[0] : -1), 32'd1);
    chk("rr_after_drop_port", 32'((gq0.size() > 0) ? gq0[0] : -1), 32'd1);
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_memory port between two requesters.
- Port 0 is the risc_v load/store path; port 1 is a loader/debug/DMA master that fills or inspects data RAM while the core runs.
- Per transaction: picks a winner (round-robin or fixed priority), registers its command, drives the memory strobes for exactly one cycle, then returns read data with a done pulse.
- One transaction is in flight at a time; the losing requester holds its request until granted.

Parameters:
- ADDR_W, 32, width of the address bus to/from data_memory.
- DATA_W, 32, width of the read/write data buses.
- RW_W, 3, width of the rw_type access-size/sign code passed through unchanged.
- FIXED_PRIO, 0. 0 = round-robin. 1 = port 0 always wins a simultaneous request.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, ACTIVE-HIGH (1 = reset), sampled on rising clk.
- m0_req  in  1  port 0 request; held with command until m0_gnt.
- m0_we  in  1  port 0: 1 = write, 0 = read.
- m0_addr  in  ADDR_W  port 0 byte address.
- m0_rw_type  in  RW_W  port 0 access type.
- m0_wdata  in  DATA_W  port 0 write data.
- m0_gnt  out  1  one-cycle pulse: port 0 command captured.
- m0_done  out  1  one-cycle pulse: port 0 access complete; m0_rdata valid this cycle.
- m0_rdata  out  DATA_W  port 0 read data; holds its value until the next m0_done.
- m0_stall  out  1  high while m0_req is high and m0_done is low; feeds core pipeline stall.
- m1_req, m1_we, m1_addr, m1_rw_type, m1_wdata, m1_gnt, m1_done, m1_rdata: same as port 0, for port 1.
- mem_wr_en  out  1  to data_memory wr_en.
- mem_rd_en  out  1  to data_memory rd_en.
- mem_addr  out  ADDR_W  to data_memory addr.
- mem_rw_type  out  RW_W  to data_memory rw_type.
- mem_wdata  out  DATA_W  to data_memory data_in.
- mem_rdata  in  DATA_W  from data_memory data_out; valid in the cycle the strobes are high.

Behaviour:
- Reset values: all gnt/done/stall/strobe outputs 0. mem_addr, mem_wdata, mem_rw_type, m0_rdata, m1_rdata all 0. FSM in IDLE. RR pointer = port 0 (port 0 preferred next).
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is high:
  - choose winner;
  - latch we/addr/rw_type/wdata and owner;
  - pulse gnt(owner) combinationally this cycle;
  - go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS: for exactly one cycle:
  - mem_wr_en = we, mem_rd_en = ~we (never both high);
  - mem_addr/rw_type/wdata driven from the latched command;
  - capture mem_rdata into a response register;
  - go to RESP.
- RESP:
  - pulse done(owner);
  - for a read, rdata(owner) = captured value; for a write, rdata(owner) is unchanged;
  - flip RR pointer to the non-owner;
  - go to IDLE.
- Latency: req sampled high in IDLE at cycle T gives gnt at T, strobes at T+1, done at T+2. Best-case throughput is one access per 3 cycles.
- Arbitration when both req are high in IDLE:
  - FIXED_PRIO=0: winner = RR pointer.
  - FIXED_PRIO=1: winner = port 0.
  - A single requester always wins regardless of the pointer.
- Requester dropping req:
  - Before gnt: no access occurs.
  - After gnt: the transaction still completes and done still pulses.
- Requests arriving during ACCESS/RESP are not sampled until IDLE.
- mem_addr/wdata/rw_type hold their last values outside ACCESS. Only the strobes gate the memory.
- Reset asserted mid-transaction: on that edge the FSM returns to IDLE and strobes drop. No done is issued; the aborted access is discarded. A write already strobed in ACCESS is not undone.
- No address decoding, no alignment check. rw_type is passed through untouched.

Decomposition:
- Shared package dmem_pkg:
  - FSM state enum (IDLE/ACCESS/RESP);
  - rw_type encodings: LB 000, LH 001, LW 010, LBU 100, LHU 101, SB/SH/SW (shared with risc_v and data_memory);
  - port index constants PORT_CORE=0, PORT_EXT=1.
- One sub-module: rr_arb2. It holds the 2-way grant logic and the pointer register, with inputs req[1:0], advance, fixed_prio. Output grant one-hot.

Test Plan:
- Reset, then m0 read: m0_req=1, m0_we=0, m0_addr=0x10, m0_rw_type=010, memory word at 0x10 = 0xDEADBEEF.
  - Required: m0_gnt at T; mem_rd_en=1, mem_addr=0x10 at T+1; m0_done=1 and m0_rdata=0xDEADBEEF at T+2; m0_stall high T..T+1, low at T+2.
- m1 write: m1_req=1, m1_we=1, m1_addr=0x20, m1_wdata=0x12345678, rw_type=SW.
  - Required: mem_wr_en=1 with those values for exactly one cycle, mem_rd_en=0 throughout.
  - Then an m0 LW to 0x20 returns 0x12345678.
- Both ports request continuously, FIXED_PRIO=0.
  - Required: grant order 0,1,0,1 across four transactions, and each done goes only to its owner.
- Same stimulus with FIXED_PRIO=1.
  - Required: port 0 granted every transaction and port 1 starves while m0_req stays high.
  - Required: port 1 granted first once m0_req drops.
- rst_n=1 during ACCESS of an m1 read.
  - Required: strobes 0 on the next edge, no m1_done, m1_rdata=0, next simultaneous request granted to port 0.
- m0 drops req one cycle after gnt.
  - Required: access still performed and m0_done pulses at T+2; m0 drops req before any gnt: no strobe issued.
